// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with a start/busy/done handshake.
// Logic, add/sub, slt and xor finish in one cycle. Multiply runs as a
// shift-add engine and divide as a restoring divider. Each takes WIDTH
// cycles.
//
// Ports:
//   clk   in   1      system clock, rising edge
//   rst   in   1      synchronous, active-high reset
//   start in   1      one-cycle request, sampled only while busy=0
//   x     in   WIDTH  operand A
//   y     in   WIDTH  operand B
//   sel   in   4      operation select
//   busy  out  1      multi-cycle operation in progress
//   done  out  1      one-cycle pulse when res and the flags update
//   res   out  WIDTH  registered result
//   zf    out  1      res == 0
//   ovf   out  1      signed overflow (add/sub only)
//   dz    out  1      last op was a divide by zero
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             zf,
    output logic             ovf,
    output logic             dz
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_NOR = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q, zf_q, ovf_q, dz_q;
    logic [WIDTH-1:0] res_q;
    // a_q: multiplicand (MUL) or dividend/quotient shift register (DIV).
    // b_q: multiplier (MUL) or divisor (DIV).
    // acc_q: product accumulator (MUL) or partial remainder (DIV).
    logic [WIDTH-1:0] a_q, b_q, acc_q;

    // Result of every op that completes in the issue cycle. The divide
    // entry is only reached when the divisor is zero.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa, sb;
        logic [WIDTH-1:0]        r;
        sa = a;
        sb = b;
        r  = '0;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_DIV: r = '1;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NOR: r = ~(a | b);
            OP_SLT: r[0] = (sa < sb);
            OP_XOR: r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic ovf_fn(input logic [3:0] op,
                                    input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic [WIDTH-1:0] r);
        logic o;
        o = 1'b0;
        if (op == OP_ADD)
            o = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        else if (op == OP_SUB)
            o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        return o;
    endfunction

    logic             multi_op, last;
    logic [WIDTH-1:0] single_res, mul_acc, div_rem, div_quot;
    logic [WIDTH:0]   div_rem_sh;
    logic             div_ge;

    assign multi_op   = (sel == OP_MUL) || ((sel == OP_DIV) && (|y));
    assign last       = (cnt_q == CNT_W'(1));
    assign single_res = alu_fn(sel, x, y);

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    assign mul_acc = b_q[0] ? (acc_q + a_q) : acc_q;

    // One restoring-divide step. The shifted remainder needs WIDTH+1 bits
    // because it can reach 2*divisor-1; when it is >= divisor the true
    // difference always fits in WIDTH bits, so a WIDTH-bit subtract suffices.
    assign div_rem_sh = {acc_q, a_q[WIDTH-1]};
    assign div_ge     = div_rem_sh[WIDTH] || (div_rem_sh[WIDTH-1:0] >= b_q);
    assign div_rem    = div_ge ? (div_rem_sh[WIDTH-1:0] - b_q) : div_rem_sh[WIDTH-1:0];
    assign div_quot   = {a_q[WIDTH-2:0], div_ge};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && (sel == OP_MUL))
                    state_d = S_MUL;
                else if (start && (sel == OP_DIV) && (|y))
                    state_d = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        res  = res_q;
        zf   = zf_q;
        ovf  = ovf_q;
        dz   = dz_q;
    end

    // Counter, result and flags; everything here is cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            res_q  <= '0;
            zf_q   <= 1'b0;
            ovf_q  <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && multi_op) begin
                        cnt_q <= CNT_W'(WIDTH);
                    end else if (start) begin
                        res_q  <= single_res;
                        zf_q   <= (single_res == '0);
                        ovf_q  <= ovf_fn(sel, x, y, single_res);
                        dz_q   <= (sel == OP_DIV);
                        done_q <= 1'b1;
                    end
                end
                S_MUL, S_DIV: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (last) begin
                        res_q  <= (state_q == S_MUL) ? mul_acc : div_quot;
                        zf_q   <= ((state_q == S_MUL) ? mul_acc : div_quot) == '0;
                        ovf_q  <= 1'b0;
                        dz_q   <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    // Iterative engine datapath; its contents are don't-care outside MUL/DIV
    always_ff @(posedge clk) begin
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_q   <= x;
                    b_q   <= y;
                    acc_q <= '0;
                end
            end
            S_MUL: begin
                a_q   <= a_q << 1;
                b_q   <= b_q >> 1;
                acc_q <= mul_acc;
            end
            S_DIV: begin
                a_q   <= div_quot;
                acc_q <= div_rem;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32. Inputs change 1 ns after a rising
// edge, and outputs are sampled at the same point, i.e. after the edge
// under test has settled.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] x, y;
    logic [3:0]   sel;
    logic         busy, done, zf, ovf, dz;
    logic [W-1:0] res;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .sel(sel),
        .busy(busy), .done(done), .res(res), .zf(zf), .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;

    // Present an op for one edge (edge N); returns just after edge N.
    task automatic issue(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        sel = s; x = a; y = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Advance edge by edge until done, counting edges after N and the
    // cycles in which busy was seen high. Bounded by budget edges.
    task automatic wait_done(input int budget, output int cyc, output int busy_cnt);
        cyc = 0; busy_cnt = 0;
        while (!done && cyc < budget) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; sel = 4'd0; x = '0; y = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if ({busy, done, zf, ovf, dz} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy, done, zf, ovf, dz});
        end
        n_checks++;
        if (res !== '0) begin
            n_fail++; $display("FAIL reset_res: got %h want 00000000", res);
        end
    endtask

    task automatic test_single;
        logic [3:0]   s_t [7] = '{4'b0000, 4'b0001, 4'b1001, 4'b0001, 4'b0100, 4'b0110, 4'b1010};
        logic [W-1:0] x_t [7] = '{32'h7FFFFFFF, 32'h5, 32'hFFFFFFFF, 32'h80000000,
                                  32'hF0F0_1234, 32'h0F0F_0000, 32'hAAAA_5555};
        logic [W-1:0] y_t [7] = '{32'h1, 32'h5, 32'h1, 32'h1,
                                  32'h0FF0_FF00, 32'h00F0_00FF, 32'hFFFF_0000};
        logic [W-1:0] r_t [7] = '{32'h80000000, 32'h0, 32'h1, 32'h7FFFFFFF,
                                  32'h00F0_1200, 32'hF000_FF00, 32'h5555_5555};
        // expected {done, busy, zf, ovf, dz}
        logic [4:0]   f_t [7] = '{5'b10010, 5'b10100, 5'b10000, 5'b10010,
                                  5'b10000, 5'b10000, 5'b10000};
        for (int i = 0; i < 7; i++) begin
            issue(s_t[i], x_t[i], y_t[i]);
            n_checks++;
            if (res !== r_t[i]) begin
                n_fail++; $display("FAIL single_res[%0d]: got %h want %h", i, res, r_t[i]);
            end
            n_checks++;
            if ({done, busy, zf, ovf, dz} !== f_t[i]) begin
                n_fail++; $display("FAIL single_flags[%0d]: got %b want %b", i, {done, busy, zf, ovf, dz}, f_t[i]);
            end
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || res !== r_t[i]) begin
                n_fail++; $display("FAIL single_hold[%0d]: got done=%b res=%h want done=0 res=%h", i, done, res, r_t[i]);
            end
        end
    endtask

    task automatic test_reset_mid_mul;
        int done_seen = 0, busy_seen = 0;
        issue(4'b0010, 32'd7, 32'd9);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b00 || res !== '0) begin
            n_fail++; $display("FAIL mid_mul_reset: got busy=%b done=%b res=%h want 0 0 0", busy, done, res);
        end
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            if (busy) busy_seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (done_seen != 0 || busy_seen != 0 || res !== '0) begin
            n_fail++; $display("FAIL mid_mul_quiet: got done=%0d busy=%0d res=%h want 0 0 0", done_seen, busy_seen, res);
        end
    endtask

    task automatic test_mul;
        int cyc, bc;
        issue(4'b0010, 32'h00012345, 32'h00000100);
        wait_done(40, cyc, bc);
        n_checks++;
        if (cyc != 32 || bc != 32) begin
            n_fail++; $display("FAIL mul_latency: got cyc=%0d busy=%0d want 32 32", cyc, bc);
        end
        n_checks++;
        if (res !== 32'h01234500 || {busy, zf, ovf, dz} !== 4'b0000) begin
            n_fail++; $display("FAIL mul_res: got %h flags=%b want 01234500 0000", res, {busy, zf, ovf, dz});
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL mul_done_pulse: got %b want 0", done);
        end
        issue(4'b0010, 32'hFFFFFFFF, 32'h2);
        wait_done(40, cyc, bc);
        n_checks++;
        if (cyc != 32 || res !== 32'hFFFFFFFE) begin
            n_fail++; $display("FAIL mul_wrap: got cyc=%0d res=%h want 32 fffffffe", cyc, res);
        end
    endtask

    task automatic test_div;
        int cyc, bc;
        issue(4'b0011, 32'h100, 32'h7);
        wait_done(40, cyc, bc);
        n_checks++;
        if (cyc != 32 || bc != 32) begin
            n_fail++; $display("FAIL div_latency: got cyc=%0d busy=%0d want 32 32", cyc, bc);
        end
        n_checks++;
        if (res !== 32'h24 || {zf, ovf, dz} !== 3'b000) begin
            n_fail++; $display("FAIL div_res: got %h flags=%b want 00000024 000", res, {zf, ovf, dz});
        end
        issue(4'b0011, 32'hFFFF_FFFF, 32'h10);
        wait_done(40, cyc, bc);
        n_checks++;
        if (cyc != 32 || res !== 32'h0FFF_FFFF) begin
            n_fail++; $display("FAIL div_big: got cyc=%0d res=%h want 32 0fffffff", cyc, res);
        end
        issue(4'b0011, 32'h9, 32'h0);
        n_checks++;
        if (res !== 32'hFFFFFFFF || {done, busy, zf, ovf, dz} !== 5'b10001) begin
            n_fail++; $display("FAIL div_zero: got %h flags=%b want ffffffff 10001", res, {done, busy, zf, ovf, dz});
        end
        issue(4'b0000, 32'h1, 32'h1);
        n_checks++;
        if (res !== 32'h2 || dz !== 1'b0) begin
            n_fail++; $display("FAIL dz_clear: got res=%h dz=%b want 00000002 0", res, dz);
        end
    endtask

    task automatic test_handshake;
        int cyc, bc;
        issue(4'b0010, 32'd3, 32'd5);
        repeat (2) begin @(posedge clk); #1; end
        sel = 4'b0000; x = 32'd100; y = 32'd200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; x = 32'hDEAD_BEEF; y = 32'h1234_5678; sel = 4'b0001;
        n_checks++;
        if ({done, busy} !== 2'b01) begin
            n_fail++; $display("FAIL busy_ignore: got done=%b busy=%b want 0 1", done, busy);
        end
        wait_done(40, cyc, bc);
        n_checks++;
        if (cyc != 29 || res !== 32'd15) begin
            n_fail++; $display("FAIL busy_result: got cyc=%0d res=%h want 29 0000000f", cyc, res);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bc;
        issue(4'b0010, 32'd6, 32'd7);
        wait_done(40, cyc, bc);
        n_checks++;
        if (cyc != 32 || res !== 32'd42) begin
            n_fail++; $display("FAIL b2b_mul: got cyc=%0d res=%h want 32 0000002a", cyc, res);
        end
        issue(4'b0000, 32'd1, 32'd2);
        n_checks++;
        if ({done, busy} !== 2'b10 || res !== 32'd3) begin
            n_fail++; $display("FAIL b2b_add: got done=%b busy=%b res=%h want 1 0 00000003", done, busy, res);
        end
        issue(4'b0001, 32'd10, 32'd4);
        n_checks++;
        if (done !== 1'b1 || res !== 32'd6) begin
            n_fail++; $display("FAIL b2b_sub: got done=%b res=%h want 1 00000006", done, res);
        end
    endtask

    task automatic test_illegal;
        issue(4'b0101, 32'h1, 32'h2);
        issue(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_checks++;
        if (res !== '0 || {done, zf, ovf, dz} !== 4'b1100) begin
            n_fail++; $display("FAIL illegal_sel: got %h flags=%b want 00000000 1100", res, {done, zf, ovf, dz});
        end
        issue(4'b0101, 32'h1, 32'h2);
        issue(4'b0111, 32'h1234, 32'h5678);
        n_checks++;
        if (res !== '0 || zf !== 1'b1) begin
            n_fail++; $display("FAIL nop_sel: got res=%h zf=%b want 00000000 1", res, zf);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid_mul();
        test_mul();
        test_div();
        test_handshake();
        test_back_to_back();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
